// File: rtl/byte_rebuffer.sv
// Packs an LSB-first byte stream into NUM_BYTES-wide words with valid/ready on
// both sides; a finished word is held until the consumer takes it.
module byte_rebuffer #(
    parameter int NUM_BYTES = 16,
    parameter int CW        = $clog2(NUM_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          count,
    output logic                   overflow
);

    logic [CW-1:0]          r_count;
    logic                   r_out_valid;
    logic                   r_overflow;
    logic [8*NUM_BYTES-1:0] r_data;

    logic          w_accept;
    logic          w_handoff;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_count_nxt;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_out_valid && out_ready;

    // A handoff frees the whole word, so a byte arriving that cycle restarts at slot 0.
    assign w_base      = w_handoff ? '0 : r_count;
    assign w_count_nxt = w_base + CW'(w_accept);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt == CW'(NUM_BYTES));
            if (in_valid && !in_ready)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_accept && !clear) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_base == CW'(i))
                    r_data[8*i +: 8] <= in_data;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_byte_rebuffer.sv
// Randomized and directed stimulus against a queue-based word model; a monitor
// compares every handed-off word against the scoreboard.
module tb_byte_rebuffer;

    localparam int N  = 16;
    localparam int CW = $clog2(N) + 1;
    localparam int W  = 8 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          clear;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;

    byte_rebuffer #(.NUM_BYTES(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: bytes of the word under construction, completed-word scoreboard,
    // and whether a finished word is waiting for the consumer.
    logic [7:0]   part[$];
    logic [W-1:0] expq[$];
    bit           pend;
    logic [W-1:0] pword;
    bit           movf;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        expq.delete();
        pend = 0;
        movf = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit ordy, input bit clr);
        bit rdy;
        bit acc;
        logic [W-1:0] w;
        @(negedge clk);
        chk("count", W'(count), pend ? W'(N) : W'(part.size()));
        chk("out_valid", W'(out_valid), W'(pend));
        chk("overflow", W'(overflow), W'(movf));
        if (pend) chk("hold", out_data, pword);
        in_valid  = v;
        in_data   = b;
        out_ready = ordy;
        clear     = clr;
        #1;
        rdy = !pend || ordy;
        chk("in_ready", W'(in_ready), W'(rdy));
        if (clr) begin
            if (pend) void'(expq.pop_back());
            part.delete();
            pend = 0;
            movf = 0;
        end else begin
            acc = v && rdy;
            if (v && !rdy) movf = 1;
            if (pend && ordy) pend = 0;
            if (acc) begin
                part.push_back(b);
                if (part.size() == N) begin
                    w = '0;
                    foreach (part[i]) w[8*i +: 8] = part[i];
                    expq.push_back(w);
                    pword = w;
                    pend  = 1;
                    part.delete();
                end
            end
        end
    endtask

    // Monitor: a word is consumed whenever out_valid && out_ready meet at an edge.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid && out_ready && !clear) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected got %h want none", out_data);
                end else begin
                    e = expq.pop_front();
                    chk("word", out_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 0; clear = 0; out_ready = 0;
        model_reset();
        #12;
        chk("rst_count", W'(count), '0);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_ovf", W'(overflow), '0);
        chk("rst_data", out_data, '0);
        @(negedge clk); rst = 1'b1;

        // Straight fill with consumer ready
        for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Backpressure and overflow
        for (int i = 0; i < 16; i++) step(1, 8'(i + 8'h40), 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Simultaneous handoff and accept
        for (int i = 0; i < 16; i++) step(1, 8'(i + 8'h80), 0, 0);
        step(1, 8'hAA, 1, 0);
        for (int i = 1; i < 16; i++) step(1, 8'(i), 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Clear mid-word, with a byte offered in the same cycle
        for (int i = 0; i < 5; i++) step(1, 8'(i + 8'h60), 0, 0);
        step(1, 8'h77, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(i + 8'h10), 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 9; i++) step(1, 8'(i + 8'hC0), 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0; in_valid = 0; out_ready = 0; clear = 0;
        #1;
        chk("arst_count", W'(count), '0);
        chk("arst_valid", W'(out_valid), '0);
        chk("arst_ovf", W'(overflow), '0);
        chk("arst_data", out_data, '0);
        model_reset();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 8'(i + 8'hE0), 0, 0);
        step(0, 0, 1, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0);

        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("scoreboard_empty", W'(expq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_rebuffer.md
Name: byte_rebuffer

Overview:
- Assembles a stream of 8-bit bytes (e.g. from the UART receiver) into one 8*NUM_BYTES-bit word.
- Byte order is LSB-first: the first byte received lands in bits [7:0]. This mirrors the order in which the 128-bit-to-byte splitter emits bytes.
- Uses a valid/ready handshake on both sides.
- Holds a completed word until the consumer accepts it.

Parameters:
- NUM_BYTES, 16, number of bytes per assembled word (output width = 8*NUM_BYTES = 128 by default).
- CW, $clog2(NUM_BYTES)+1, width of the byte counter (5 by default). Derived; do not override.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a byte this cycle (combinational).
- clear  input  1  synchronous discard of the partial word and of the overflow flag.
- out_data  output  8*NUM_BYTES  assembled word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word this cycle.
- count  output  CW  number of bytes currently stored (0..NUM_BYTES).
- overflow  output  1  sticky flag: a byte was offered while in_ready=0.

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed):
  - count=0, out_valid=0, overflow=0, out_data=0.
  - Applies mid-word too; the partial word is lost.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising edge.
  - Write in_data into out_data[8*slot +: 8].
  - slot = count, or slot = 0 if a handoff occurs in the same cycle.
- Fill: each accept increments count.
  - The accept that makes count == NUM_BYTES also sets out_valid=1 on the same edge.
  - Latency: out_valid is visible the cycle after the last byte is accepted.
- Full (out_valid=1, out_ready=0):
  - count stays at NUM_BYTES, out_data is held stable, in_ready=0.
- Handoff: out_valid && out_ready at an edge.
  - The word is consumed.
  - With no simultaneous accept: out_valid=0, count=0 next cycle.
- Simultaneous handoff and accept: new byte goes to slot 0, count=1, out_valid=0.
  - Throughput: one byte per clock, no bubble between words.
- NUM_BYTES=1 with handoff and accept in the same cycle: out_valid stays 1 and count stays 1 (the new byte completes a word).
- Unwritten slots keep their previous contents. out_data is only meaningful while out_valid=1.
- Overflow: in_valid && !in_ready sets overflow=1 (sticky).
  - The byte is dropped; count and out_data are unchanged.
- clear=1 at an edge: count=0, out_valid=0, overflow=0.
  - Takes priority over in_valid and out_ready in that cycle.
  - Any byte offered that cycle is dropped and does not set overflow.
  - out_data contents are not required to change.
- Counter arithmetic: CW bits; never exceeds NUM_BYTES; no wrap-around.
- State summary:
  - FILL (out_valid=0, 0 <= count < NUM_BYTES) -> FULL on the NUM_BYTES-th accept.
  - FULL -> FILL on handoff or clear.
  - Any state -> FILL/empty on reset.

Test Plan:
- Fill with out_ready=1: after reset, 16 back-to-back bytes 0x00..0x0F.
  - Cycle after the 16th accept: out_valid=1, out_data=0x0F0E0D0C0B0A09080706050403020100, count=16.
  - Next cycle: out_valid=0, count=0.
- Backpressure: fill 16 bytes with out_ready=0, then offer 0x55.
  - in_ready=0, overflow=1, out_data unchanged, count=16.
  - Raise out_ready: one-cycle handoff, overflow stays 1.
- Simultaneous: in FULL, assert out_ready=1 and in_valid=1 with 0xAA in the same cycle.
  - Next cycle: out_valid=0, count=1, out_data[7:0]=0xAA.
  - 15 more bytes 0x01..0x0F give out_data=0x0F0E...0201AA.
- Clear: after 5 bytes, pulse clear with in_valid=1 (byte 0x77).
  - count=0, overflow=0, 0x77 not stored.
  - 16 bytes 0x10..0x1F then yield out_data=0x1F1E...1110.
- Async reset: after 9 bytes, drive rst=0 between clock edges.
  - count=0, out_valid=0, overflow=0, out_data=0 immediately.
  - After release, a full 16-byte word assembles normally.
